// File: rtl/ahb_lite_master_if_pkg.sv
// Shared AHB-Lite types and constants for the two-slave memory subsystem and its upstream master.
package Definitions;

    localparam int DATAWIDTH        = 32;
    localparam int ADDRWIDTH        = 32;
    localparam int DATATRANFER_SIZE = 3;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } BType_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } Trans_t;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } Response_t;

    typedef enum logic [2:0] {
        M_IDLE,
        M_ADDR,
        M_BURST,
        M_LAST,
        M_ERR
    } MstState_t;

    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // Command context kept for the whole burst: start address drives wrap/linear address generation.
    typedef struct packed {
        logic [ADDRWIDTH-1:0]        base;
        logic [3:0][DATAWIDTH-1:0]   wdata;
    } mst_cmd_t;

    // Only the fixed 4-beat bursts are issued as bursts; everything else degrades to SINGLE.
    function automatic logic [2:0] norm_burst(input logic [2:0] b);
        return (b == INCR4 || b == WRAP4) ? b : 3'(SINGLE);
    endfunction

endpackage

// File: rtl/ahb_lite_master_if_addr_gen.sv
// Beat address for a burst, computed from the start address and beat index (linear or WRAP4).
module ahb_master_addr_gen
    import Definitions::*;
(
    input  logic [ADDRWIDTH-1:0]        base,
    input  logic [DATATRANFER_SIZE-1:0] size,
    input  logic [2:0]                  burst,
    input  logic [1:0]                  beat,
    output logic [ADDRWIDTH-1:0]        addr
);

    logic [ADDRWIDTH-1:0] step;
    logic [ADDRWIDTH-1:0] lin;
    logic [ADDRWIDTH-1:0] wrap_mask;

    always_comb begin
        step      = ADDRWIDTH'(1) << size;
        lin       = base + (ADDRWIDTH'(beat) << size);
        // WRAP4 stays inside the (4 << size)-byte block holding the start address
        wrap_mask = (step << 2) - ADDRWIDTH'(1);
        addr      = lin;
        if (burst == WRAP4)
            addr = (base & ~wrap_mask) | (lin & wrap_mask);
    end

endmodule

// File: rtl/ahb_lite_master_if.sv
// AHB-Lite master: turns one-at-a-time SINGLE/INCR4/WRAP4 commands into pipelined bus transfers.
module ahb_lite_master_if
    import Definitions::*;
(
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ADDRWIDTH-1:0]          cmd_addr,
    input  logic                          cmd_write,
    input  logic [2:0]                    cmd_burst,
    input  logic [DATATRANFER_SIZE-1:0]   cmd_size,
    input  logic [4*DATAWIDTH-1:0]        cmd_wdata,
    output logic                          rd_valid,
    output logic [DATAWIDTH-1:0]          rd_data,
    output logic                          done,
    output logic                          done_err,
    output logic [ADDRWIDTH-1:0]          HADDR,
    output logic                          HWRITE,
    output logic [DATATRANFER_SIZE-1:0]   HSIZE,
    output logic [2:0]                    HBURST,
    output logic [1:0]                    HTRANS,
    output logic [DATAWIDTH-1:0]          HWDATA,
    output logic                          HMASTLOCK,
    output logic [3:0]                    HPROT,
    input  logic [DATAWIDTH-1:0]          HRDATA,
    input  logic                          HREADY,
    input  logic                          HRESP
);

    MstState_t                    state, state_nx;
    mst_cmd_t                     cmd_q, cmd_nx;
    logic [1:0]                   beat, beat_nx;
    logic                         dp_valid, dp_valid_nx;
    logic                         dp_write, dp_write_nx;
    logic                         dp_last, dp_last_nx;
    logic [ADDRWIDTH-1:0]         haddr_nx, next_addr;
    logic                         hwrite_nx;
    logic [DATATRANFER_SIZE-1:0]  hsize_nx;
    logic [2:0]                   hburst_nx;
    logic [1:0]                   htrans_nx;
    logic [DATAWIDTH-1:0]         hwdata_nx, rd_data_nx;
    logic                         rd_valid_nx, done_nx, done_err_nx;
    logic                         addr_acc, last_beat, err_now;
    logic [1:0]                   beat_inc;

    assign cmd_ready = (state == M_IDLE);
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_DEFAULT;
    assign beat_inc  = beat + 2'd1;

    ahb_master_addr_gen u_addr_gen (
        .base  (cmd_q.base),
        .size  (HSIZE),
        .burst (HBURST),
        .beat  (beat_inc),
        .addr  (next_addr)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state    <= M_IDLE;
            cmd_q    <= '0;
            beat     <= 2'd0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_last  <= 1'b0;
            HADDR    <= '0;
            HWRITE   <= 1'b0;
            HSIZE    <= '0;
            HBURST   <= SINGLE;
            HTRANS   <= IDLE;
            HWDATA   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            done     <= 1'b0;
            done_err <= 1'b0;
        end else begin
            state    <= state_nx;
            cmd_q    <= cmd_nx;
            beat     <= beat_nx;
            dp_valid <= dp_valid_nx;
            dp_write <= dp_write_nx;
            dp_last  <= dp_last_nx;
            HADDR    <= haddr_nx;
            HWRITE   <= hwrite_nx;
            HSIZE    <= hsize_nx;
            HBURST   <= hburst_nx;
            HTRANS   <= htrans_nx;
            HWDATA   <= hwdata_nx;
            rd_valid <= rd_valid_nx;
            rd_data  <= rd_data_nx;
            done     <= done_nx;
            done_err <= done_err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cmd_nx      = cmd_q;
        beat_nx     = beat;
        dp_valid_nx = dp_valid;
        dp_write_nx = dp_write;
        dp_last_nx  = dp_last;
        haddr_nx    = HADDR;
        hwrite_nx   = HWRITE;
        hsize_nx    = HSIZE;
        hburst_nx   = HBURST;
        htrans_nx   = HTRANS;
        hwdata_nx   = HWDATA;
        rd_valid_nx = 1'b0;
        rd_data_nx  = rd_data;
        done_nx     = 1'b0;
        done_err_nx = 1'b0;

        addr_acc  = HTRANS[1] & HREADY;
        last_beat = (HBURST == SINGLE) || (beat == 2'd3);
        // The ERR state already owns the second error cycle
        err_now   = dp_valid && (HRESP == ERROR) && (state != M_ERR);

        // Data-phase pipeline: an accepted address phase becomes next cycle's data phase
        if (HREADY) begin
            dp_valid_nx = addr_acc;
            if (addr_acc) begin
                dp_write_nx = HWRITE;
                dp_last_nx  = last_beat;
                if (HWRITE)
                    hwdata_nx = cmd_q.wdata[beat];
            end
            if (dp_valid && HRESP == OKAY) begin
                rd_valid_nx = ~dp_write;
                if (!dp_write)
                    rd_data_nx = HRDATA;
                done_nx = dp_last;
            end
        end

        case (state)
            M_IDLE: begin
                if (cmd_valid) begin
                    state_nx     = M_ADDR;
                    htrans_nx    = NONSEQ;
                    haddr_nx     = cmd_addr;
                    hwrite_nx    = cmd_write;
                    hsize_nx     = cmd_size;
                    hburst_nx    = norm_burst(cmd_burst);
                    beat_nx      = 2'd0;
                    cmd_nx.base  = cmd_addr;
                    cmd_nx.wdata = cmd_wdata;
                end
            end
            M_ADDR, M_BURST: begin
                if (HREADY) begin
                    if (last_beat) begin
                        state_nx  = M_LAST;
                        htrans_nx = IDLE;
                    end else begin
                        state_nx  = M_BURST;
                        htrans_nx = SEQ;
                        haddr_nx  = next_addr;
                        beat_nx   = beat_inc;
                    end
                end
            end
            M_LAST: begin
                if (HREADY)
                    state_nx = M_IDLE;
            end
            M_ERR: begin
                if (HREADY) begin
                    state_nx    = M_IDLE;
                    done_nx     = 1'b1;
                    done_err_nx = 1'b1;
                    rd_valid_nx = 1'b0;
                    dp_valid_nx = 1'b0;
                end
            end
            default: state_nx = M_IDLE;
        endcase

        // First error cycle cancels any pending address phase; an ERROR already carrying
        // HREADY=1 is taken as the second cycle and completes the command at once.
        if (err_now) begin
            htrans_nx   = IDLE;
            rd_valid_nx = 1'b0;
            done_nx     = 1'b0;
            if (HREADY) begin
                state_nx    = M_IDLE;
                done_nx     = 1'b1;
                done_err_nx = 1'b1;
                dp_valid_nx = 1'b0;
            end else begin
                state_nx = M_ERR;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_master_if.sv
// Self-checking bench: a cycle-level slave/monitor plus a per-command reference model of addresses and data.
module tb_ahb_lite_master_if;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic         cmd_valid, cmd_ready, cmd_write;
    logic [31:0]  cmd_addr;
    logic [2:0]   cmd_burst, cmd_size;
    logic [127:0] cmd_wdata;
    logic         rd_valid, done, done_err;
    logic [31:0]  rd_data;
    logic [31:0]  HADDR, HWDATA, HRDATA;
    logic         HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]   HSIZE, HBURST;
    logic [1:0]   HTRANS;
    logic [3:0]   HPROT;

    int checks = 0;
    int errors = 0;

    logic [31:0]  sl_mem  [256];
    logic [31:0]  ref_mem [256];

    logic [31:0]  hold_addr;
    logic         hold_wr;
    logic [2:0]   hold_burst, hold_size;
    logic [127:0] hold_wd;

    always #5 HCLK = ~HCLK;

    ahb_lite_master_if dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_write(cmd_write),
        .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .done_err(done_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // One command end to end. wt holds per-beat wait states (4 bits each); err_beat < 0 means no ERROR.
    // pre: command already presented on cmd_*; hold: keep cmd_valid high with hold_* fields while busy.
    task automatic run_cmd(input string tag, input logic [31:0] addr, input logic wr, input logic [2:0] burst,
                           input logic [2:0] size, input logic [127:0] wd, input logic [15:0] wt,
                           input int err_beat, input bit pre, input bit hold);
        int unsigned step, blk;
        int          nb, ok_beats, n_addr, n_rd, n_wr, it, waits_tot, wleft, ecyc, dp_beat, exp_addrs;
        logic [31:0] ea [4];
        logic [31:0] exp_rd [4];
        logic [2:0]  eburst;
        logic [1:0]  p_trans;
        logic [31:0] p_addr, p_wdata;
        bit          dp, got_done, p_frz;

        nb       = (burst == 3'b010 || burst == 3'b011) ? 4 : 1;
        eburst   = (nb == 4) ? burst : 3'b000;
        step     = 1 << size;
        blk      = 4 * step;
        ok_beats = (err_beat >= 0) ? err_beat : nb;
        exp_addrs = (err_beat >= 0) ? err_beat + 1 : nb;
        for (int n = 0; n < 4; n++) begin
            if (burst == 3'b010)
                ea[n] = (addr - (addr % blk)) + ((addr % blk + 32'(n) * step) % blk);
            else
                ea[n] = addr + 32'(n) * step;
        end
        for (int n = 0; n < 4; n++) begin
            exp_rd[n] = '0;
            if (n < ok_beats) begin
                if (wr) ref_mem[ea[n][9:2]] = wd[n*32 +: 32];
                else    exp_rd[n] = ref_mem[ea[n][9:2]];
            end
        end

        if (!pre) begin
            @(negedge HCLK);
            cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr;
            cmd_burst = burst; cmd_size = size; cmd_wdata = wd;
        end
        HREADY = 1'b1; HRESP = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s cmd_ready_idle got %b want 1", tag, cmd_ready);
        end
        @(posedge HCLK);

        dp = 0; dp_beat = 0; wleft = 0; ecyc = 0; n_addr = 0; n_rd = 0; n_wr = 0;
        waits_tot = 0; got_done = 0; p_frz = 0; it = 0;
        p_trans = '0; p_addr = '0; p_wdata = '0;
        while (it < 200 && !got_done) begin
            it++;
            @(negedge HCLK);
            if (hold) begin
                cmd_valid = 1'b1; cmd_addr = hold_addr; cmd_write = hold_wr;
                cmd_burst = hold_burst; cmd_size = hold_size; cmd_wdata = hold_wd;
            end else begin
                cmd_valid = 1'b0;
            end

            if (p_frz) begin
                checks++;
                if ({HTRANS, HADDR, HWDATA} !== {p_trans, p_addr, p_wdata}) begin
                    errors++;
                    $display("FAIL %s wait_freeze got %h/%h/%h want %h/%h/%h", tag, HTRANS, HADDR, HWDATA,
                             p_trans, p_addr, p_wdata);
                end
            end
            if (rd_valid) begin
                checks++;
                if (wr || n_rd >= ok_beats) begin
                    errors++; $display("FAIL %s rd_valid_extra got beat %0d want at most %0d", tag, n_rd, ok_beats);
                end else if (rd_data !== exp_rd[n_rd]) begin
                    errors++; $display("FAIL %s rd_data[%0d] got %h want %h", tag, n_rd, rd_data, exp_rd[n_rd]);
                end
                n_rd++;
            end
            if (done) begin
                got_done = 1;
                checks++;
                if (done_err !== (err_beat >= 0)) begin
                    errors++; $display("FAIL %s done_err got %b want %b", tag, done_err, err_beat >= 0);
                end
                checks++;
                if (n_addr != exp_addrs) begin
                    errors++; $display("FAIL %s addr_phases got %0d want %0d", tag, n_addr, exp_addrs);
                end
                checks++;
                if (n_rd != (wr ? 0 : ok_beats) || n_wr != (wr ? ok_beats : 0)) begin
                    errors++; $display("FAIL %s beats got rd %0d wr %0d want %0d", tag, n_rd, n_wr, ok_beats);
                end
                if (err_beat < 0) begin
                    checks++;
                    if (it != nb + 2 + waits_tot) begin
                        errors++; $display("FAIL %s done_cycle got %0d want %0d", tag, it, nb + 2 + waits_tot);
                    end
                    if (!wr) begin
                        checks++;
                        if (rd_valid !== 1'b1) begin
                            errors++; $display("FAIL %s done_with_last_rd got rd_valid %b want 1", tag, rd_valid);
                        end
                    end
                end
            end else begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    errors++; $display("FAIL %s cmd_ready_busy got %b want 0", tag, cmd_ready);
                end
            end

            // Slave response for the posedge that follows
            HREADY = 1'b1; HRESP = 1'b0;
            if (dp) begin
                if (wleft > 0) begin
                    HREADY = 1'b0; wleft--; waits_tot++;
                end else if (dp_beat == err_beat && ecyc == 0) begin
                    HREADY = 1'b0; HRESP = 1'b1; ecyc = 1;
                end else if (dp_beat == err_beat) begin
                    HRESP = 1'b1;
                    checks++;
                    if (HTRANS !== 2'b00) begin
                        errors++; $display("FAIL %s htrans_err2 got %b want 00", tag, HTRANS);
                    end
                end else if (wr) begin
                    checks++;
                    if (HWDATA !== wd[dp_beat*32 +: 32]) begin
                        errors++; $display("FAIL %s hwdata[%0d] got %h want %h", tag, dp_beat, HWDATA, wd[dp_beat*32 +: 32]);
                    end
                    sl_mem[ea[dp_beat][9:2]] = HWDATA;
                    n_wr++;
                end else begin
                    HRDATA = sl_mem[ea[dp_beat][9:2]];
                end
            end
            if (HREADY) begin
                dp = 0;
                if (HTRANS[1]) begin
                    checks++;
                    if (n_addr >= nb) begin
                        errors++; $display("FAIL %s extra_addr got %h want none", tag, HADDR);
                    end else if (HADDR !== ea[n_addr] || HTRANS !== (n_addr == 0 ? 2'b10 : 2'b11) ||
                                 HWRITE !== wr || HSIZE !== size || HBURST !== eburst) begin
                        errors++;
                        $display("FAIL %s addr_phase[%0d] got %h/%b/%b/%0d/%b want %h/%b/%b/%0d/%b", tag, n_addr,
                                 HADDR, HTRANS, HWRITE, HSIZE, HBURST, ea[n_addr], (n_addr == 0 ? 2'b10 : 2'b11),
                                 wr, size, eburst);
                    end
                    dp = (n_addr < 4);
                    dp_beat = n_addr;
                    wleft = (n_addr < 4) ? int'(wt[n_addr*4 +: 4]) : 0;
                    ecyc = 0;
                    n_addr++;
                end
            end
            p_frz = !HREADY && !HRESP;
            p_trans = HTRANS; p_addr = HADDR; p_wdata = HWDATA;
        end
        if (!got_done) begin
            checks++; errors++;
            $display("FAIL %s timeout got no done want done within 200 cycles", tag);
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        checks++;
        if ({HTRANS, HADDR, HWRITE, HWDATA} !== {2'b00, 32'h0, 1'b0, 32'h0}) begin
            errors++; $display("FAIL reset_bus got %b/%h/%b/%h want 00/0/0/0", HTRANS, HADDR, HWRITE, HWDATA);
        end
        checks++;
        if ({HSIZE, HBURST, HMASTLOCK, HPROT} !== {3'd0, 3'd0, 1'b0, 4'b0011}) begin
            errors++; $display("FAIL reset_ctrl got %0d/%b/%b/%b want 0/000/0/0011", HSIZE, HBURST, HMASTLOCK, HPROT);
        end
        checks++;
        if ({rd_valid, done, done_err, cmd_ready} !== 4'b0001) begin
            errors++; $display("FAIL reset_status got %b want 0001", {rd_valid, done, done_err, cmd_ready});
        end
        HRESETn = 1'b1;
    endtask

    task automatic test_single_write();
        run_cmd("single_wr", 32'h10, 1'b1, 3'b000, 3'd2, 128'hDEADBEEF, 16'h0, -1, 0, 0);
    endtask

    task automatic test_incr4_read_waits();
        run_cmd("incr4_rd", 32'h104, 1'b0, 3'b011, 3'd2, 128'h0, 16'h0002, -1, 0, 0);
    endtask

    task automatic test_wrap4_write();
        run_cmd("wrap4_wr", 32'h38, 1'b1, 3'b010, 3'd2,
                {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 16'h0, -1, 0, 0);
        run_cmd("wrap4_rdback", 32'h30, 1'b0, 3'b011, 3'd2, 128'h0, 16'h1010, -1, 0, 0);
    endtask

    task automatic test_error();
        run_cmd("incr4_err", 32'h80, 1'b1, 3'b011, 3'd2,
                {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'h0, 1, 0, 0);
        run_cmd("single_rd_err", 32'h84, 1'b0, 3'b000, 3'd2, 128'h0, 16'h0001, 0, 0, 0);
    endtask

    task automatic test_illegal_burst();
        run_cmd("incr_as_single", 32'h2C, 1'b0, 3'b001, 3'd2, 128'h0, 16'h0, -1, 0, 0);
    endtask

    task automatic test_back_to_back();
        hold_addr = 32'h204; hold_wr = 1'b0; hold_burst = 3'b000; hold_size = 3'd2; hold_wd = '1;
        run_cmd("hold_a", 32'h200, 1'b1, 3'b011, 3'd2,
                {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 16'h0100, -1, 0, 1);
        run_cmd("hold_b", 32'h204, 1'b0, 3'b000, 3'd2, '1, 16'h0, -1, 1, 0);
    endtask

    task automatic test_reset_mid_burst();
        @(negedge HCLK);
        cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_write = 1'b0; cmd_burst = 3'b011; cmd_size = 3'd2;
        HREADY = 1'b1; HRESP = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        cmd_valid = 1'b0;
        repeat (2) @(negedge HCLK);
        checks++;
        if (HADDR !== 32'h108 || HTRANS !== 2'b11) begin
            errors++; $display("FAIL rst_mid_beat2 got %h/%b want 00000108/11", HADDR, HTRANS);
        end
        HRESETn = 1'b0;
        @(negedge HCLK);
        checks++;
        if ({HTRANS, HADDR, cmd_ready, done, rd_valid} !== {2'b00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_state got %b/%h/%b/%b/%b want 00/0/1/0/0", HTRANS, HADDR, cmd_ready, done, rd_valid);
        end
        HRESETn = 1'b1;
        repeat (3) begin
            @(negedge HCLK);
            checks++;
            if ({done, rd_valid, HTRANS} !== 4'b0000) begin
                errors++; $display("FAIL rst_mid_quiet got %b want 0000", {done, rd_valid, HTRANS});
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]   b, sz;
        logic [31:0]  a;
        logic [127:0] wd;
        int           sel, nb, eb;
        for (int k = 0; k < 30; k++) begin
            sz  = 3'($urandom_range(0, 2));
            sel = $urandom_range(0, 3);
            b   = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b011 : (sel == 2) ? 3'b010 :
                  ($urandom_range(0, 1) ? 3'b001 : 3'b101);
            a   = 32'($urandom_range(0, 1023)) & ~((32'd1 << sz) - 32'd1);
            wd  = {$urandom, $urandom, $urandom, $urandom};
            nb  = (b == 3'b010 || b == 3'b011) ? 4 : 1;
            eb  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nb - 1) : -1;
            run_cmd($sformatf("rand%0d", k), a, 1'($urandom_range(0, 1)), b, sz, wd,
                    16'($urandom) & 16'h3333, eb, 0, 0);
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_burst = '0; cmd_size = '0; cmd_wdata = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0; HRESETn = 1'b0;
        hold_addr = '0; hold_wr = 1'b0; hold_burst = '0; hold_size = '0; hold_wd = '0;
        for (int i = 0; i < 256; i++) begin
            sl_mem[i]  = $urandom;
            ref_mem[i] = sl_mem[i];
        end
        test_reset();
        test_single_write();
        test_incr4_read_waits();
        test_wrap4_write();
        test_error();
        test_illegal_burst();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
